port_in_debouncer: RTL and testbench
====================================

// Module: port_in_debouncer
// PURPOSE
//   Upstream conditioning stage for one computer input port (port_in_00..15).
//   Synchronises an asynchronous 8-bit switch/button bus into the clk domain,
//   debounces each bit independently and presents a clean registered byte.
//   One instance per used input port; data_out wires straight to port_in_NN.
// PARAMETERS
//   WIDTH            8       bits per port
//   DEBOUNCE_CYCLES  50000   consecutive stable cycles before a bit changes (>=1)
//   RESET_VALUE      8'h00   value of data_out and all sync stages after reset
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-high reset
//   raw_in      in   WIDTH  asynchronous pin levels
//   data_out    out  WIDTH  debounced level -> port_in_NN
//   changed     out  1      1-cycle pulse: data_out updated this cycle
// BEHAVIOUR
//   - Reset (async assert, sync use): sync1, sync2, data_out <= RESET_VALUE;
//     all counters <= 0; changed <= 0. No output pulse on reset release.
//   - Sync: 2-flop chain per bit, raw_in -> sync1 -> sync2. No logic between.
//   - Per bit i, counter cnt[i], width CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)):
//       sync2[i] == data_out[i]           : cnt[i] <= 0
//       mismatch, cnt[i] <  D-1           : cnt[i] <= cnt[i]+1
//       mismatch, cnt[i] == D-1           : data_out[i] <= sync2[i]; cnt[i] <= 0
//   - Any single-cycle return to match clears the counter (restart, no memory).
//   - Latency: level change held stable, first sampled at edge 1 -> data_out
//     updates at edge D+2. D=1 -> edge 3 (pure 2-flop sync + 1 register).
//   - changed = OR over bits of "updated on this edge", registered, high for
//     exactly one cycle per update edge; several bits on one edge -> one pulse.
//   - Bits fully independent; simultaneous toggles of different bits with
//     different settle times update on their own edges.
//   - Counter never exceeds D-1; no wrap possible.
//   - Reset mid-count: counters discarded, data_out returns to RESET_VALUE.
// CONFIGURATION
//   PORT_IN_EDGE_EN defined: extra outputs
//     rise_pulse  out  WIDTH  1-cycle pulse per bit on 0->1 update of data_out
//     fall_pulse  out  WIDTH  1-cycle pulse per bit on 1->0 update of data_out
//     Registered, aligned with the same edge as changed; reset 0.
//   PORT_IN_EDGE_EN undefined: ports and logic absent; data_out/changed identical.
// TESTING  (D=4, WIDTH=8, RESET_VALUE=0 unless noted)
//   1 raw_in 00->01 held -> data_out=01 at edge 6, changed=1 that cycle only.
//   2 raw_in bit0 toggles every 3 cycles for 40 cycles -> data_out stays 00,
//     changed never asserts.
//   3 raw_in 00->81 same edge, held -> data_out 81 at edge 6, single changed pulse;
//     with PORT_IN_EDGE_EN rise_pulse=81, fall_pulse=00 that cycle.
//   4 data_out=FF, raw_in->00, reset pulsed at edge 4 -> data_out=00 immediately
//     (async), no changed pulse after release; raw_in=00 keeps data_out=00.
//   5 D=1: raw_in 00->5A -> data_out=5A at edge 3.
//   6 RESET_VALUE=FF, raw_in=FF from reset -> data_out FF, zero changed pulses.

Source files
------------

// File: rtl/port_in_debouncer_if.sv
// Bus bundle for port_in_debouncer: raw pin levels in, debounced byte and change pulse out.
// With PORT_IN_EDGE_EN defined, per-bit rise/fall pulses are carried as well.
interface port_in_debouncer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] data_out;
  logic             changed;
`ifdef PORT_IN_EDGE_EN
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (output raw_in, input data_out, input changed,
                  input rise_pulse, input fall_pulse);
  modport slave  (input raw_in, output data_out, output changed,
                  output rise_pulse, output fall_pulse);
`else
  modport master (output raw_in, input data_out, input changed);
  modport slave  (input raw_in, output data_out, output changed);
`endif
endinterface

// File: rtl/port_in_debouncer.sv
// Input-port conditioner: 2-flop synchroniser then an independent debounce counter per bit.
// Optional PORT_IN_EDGE_EN adds registered per-bit rise_pulse/fall_pulse outputs.
module port_in_debouncer #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input logic                 clk,
  input logic                 reset,
  port_in_debouncer_if.slave  bus
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] upd;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // A bit flips only after D consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    data_d = data_q;
    upd    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          upd[i]    = 1'b1;
          data_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      data_q    <= RESET_VALUE;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.raw_in;
      sync2_q   <= sync1_q;
      data_q    <= data_d;
      changed_q <= |upd;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.changed  = changed_q;

`ifdef PORT_IN_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // sync2_q is the value being adopted on an update edge, so it gives the direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & sync2_q;
      fall_q <= upd & ~sync2_q;
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_port_in_debouncer.sv
// Self-checking bench for port_in_debouncer: directed scenarios plus randomized holds
// checked against a run-length reference model.
module tb_port_in_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   pulses_f = 0;

  always #5 clk = ~clk;

  port_in_debouncer_if #(.WIDTH(8)) bus_m ();
  port_in_debouncer_if #(.WIDTH(8)) bus_1 ();
  port_in_debouncer_if #(.WIDTH(8)) bus_f ();

  port_in_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .RESET_VALUE(8'h00)) u_dut (
    .clk(clk), .reset(rst), .bus(bus_m));
  port_in_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .RESET_VALUE(8'h00)) u_dut1 (
    .clk(clk), .reset(rst), .bus(bus_1));
  port_in_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .RESET_VALUE(8'hFF)) u_dutf (
    .clk(clk), .reset(rst), .bus(bus_f));

  // Reference model: raw samples pass a two-deep delay; each bit tracks how long the
  // delayed value has disagreed with the output, adopting it after D disagreeing cycles.
  logic [7:0] m_dly [$];
  logic [7:0] m_out, m_rise, m_fall, m_seen, m_flip;
  logic       m_chg;
  int         m_run [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dly = '{8'h00, 8'h00};
      m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_chg = 1'b0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      m_seen = m_dly[0];
      m_flip = 8'h00;
      for (int i = 0; i < 8; i++) begin
        m_run[i] = (m_seen[i] !== m_out[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == D) begin
          m_flip[i] = 1'b1;
          m_run[i]  = 0;
        end
      end
      m_rise = m_flip & m_seen;
      m_fall = m_flip & ~m_seen;
      m_out  = m_out ^ m_flip;
      m_chg  = (m_flip != 8'h00);
      void'(m_dly.pop_front());
      m_dly.push_back(bus_m.raw_in);
    end
  end

  always @(negedge clk) if (!rst && bus_f.changed === 1'b1) pulses_f++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [7:0] raw);
    @(negedge clk);
    rst = 1'b1;
    bus_m.raw_in = raw;
    bus_1.raw_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus_m.data_out !== 8'h00 || bus_m.changed !== 1'b0) begin
      bad++; $display("FAIL reset_main: data=%h chg=%b want 00/0", bus_m.data_out, bus_m.changed);
    end
    total++;
    if (bus_f.data_out !== 8'hFF) begin
      bad++; $display("FAIL reset_value_ff: data=%h want FF", bus_f.data_out);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus_m.data_out !== 8'h00 || bus_m.changed !== 1'b0) begin
      bad++; $display("FAIL reset_release: data=%h chg=%b want 00/0", bus_m.data_out, bus_m.changed);
    end
  endtask

  task automatic test_single();
    do_reset(8'h00);
    bus_m.raw_in = 8'h01;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      total++;
      if (bus_m.data_out !== ((e >= 6) ? 8'h01 : 8'h00) || bus_m.changed !== (e == 6)) begin
        bad++;
        $display("FAIL single_edge%0d: data=%h chg=%b want %h/%b", e, bus_m.data_out,
                 bus_m.changed, (e >= 6) ? 8'h01 : 8'h00, (e == 6));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(8'h00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c % 3 == 0) bus_m.raw_in[0] = ~bus_m.raw_in[0];
      @(posedge clk); #1;
      total++;
      if (bus_m.data_out !== 8'h00 || bus_m.changed !== 1'b0) begin
        bad++; $display("FAIL glitch_c%0d: data=%h chg=%b want 00/0", c, bus_m.data_out, bus_m.changed);
      end
    end
    bus_m.raw_in = 8'h00;
  endtask

  task automatic test_multi();
    int pulses = 0;
    do_reset(8'h00);
    bus_m.raw_in = 8'h81;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (bus_m.changed === 1'b1) pulses++;
      if (e == 6) begin
        total++;
        if (bus_m.data_out !== 8'h81 || bus_m.changed !== 1'b1) begin
          bad++; $display("FAIL multi_edge6: data=%h chg=%b want 81/1", bus_m.data_out, bus_m.changed);
        end
`ifdef PORT_IN_EDGE_EN
        total++;
        if (bus_m.rise_pulse !== 8'h81 || bus_m.fall_pulse !== 8'h00) begin
          bad++; $display("FAIL multi_edges: rise=%h fall=%h want 81/00", bus_m.rise_pulse, bus_m.fall_pulse);
        end
`endif
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL multi_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(8'h00);
    bus_m.raw_in = 8'hFF;
    repeat (10) @(negedge clk);
    bus_m.raw_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus_m.data_out !== 8'hFF) begin
      bad++; $display("FAIL midreset_pre: data=%h want FF", bus_m.data_out);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus_m.data_out !== 8'h00 || bus_m.changed !== 1'b0) begin
      bad++; $display("FAIL midreset_async: data=%h chg=%b want 00/0", bus_m.data_out, bus_m.changed);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus_m.data_out !== 8'h00 || bus_m.changed !== 1'b0) begin
        bad++; $display("FAIL midreset_after%0d: data=%h chg=%b want 00/0", c, bus_m.data_out, bus_m.changed);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] val;
    int hold;
    do_reset(8'h00);
    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 1) == 0) val = bus_m.raw_in ^ (8'h01 << $urandom_range(0, 7));
      else                           val = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold + ((s == 69) ? 8 : 0); h++) begin
        @(negedge clk);
        if (h == 0) bus_m.raw_in = val;
        @(posedge clk); #1;
        total++;
        if (bus_m.data_out !== m_out || bus_m.changed !== m_chg) begin
          bad++; $display("FAIL random_s%0d: data=%h chg=%b want %h/%b", s, bus_m.data_out,
                          bus_m.changed, m_out, m_chg);
        end
`ifdef PORT_IN_EDGE_EN
        total++;
        if (bus_m.rise_pulse !== m_rise || bus_m.fall_pulse !== m_fall) begin
          bad++; $display("FAIL random_edges_s%0d: rise=%h fall=%h want %h/%h", s,
                          bus_m.rise_pulse, bus_m.fall_pulse, m_rise, m_fall);
        end
`endif
      end
    end
  endtask

  task automatic test_d1();
    do_reset(8'h00);
    bus_1.raw_in = 8'h5A;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      total++;
      if (bus_1.data_out !== ((e >= 3) ? 8'h5A : 8'h00) || bus_1.changed !== (e == 3)) begin
        bad++; $display("FAIL d1_edge%0d: data=%h chg=%b want %h/%b", e, bus_1.data_out,
                        bus_1.changed, (e >= 3) ? 8'h5A : 8'h00, (e == 3));
      end
    end
  endtask

  task automatic test_rv_ff();
    repeat (5) @(negedge clk);
    total++;
    if (bus_f.data_out !== 8'hFF || pulses_f != 0) begin
      bad++; $display("FAIL rv_ff: data=%h pulses=%0d want FF/0", bus_f.data_out, pulses_f);
    end
  endtask

  initial begin
    bus_m.raw_in = 8'h00;
    bus_1.raw_in = 8'h00;
    bus_f.raw_in = 8'hFF;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_multi();
    test_reset_mid();
    test_random();
    test_d1();
    test_rv_ff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
